// File: rtl/rr_arb_stage.sv
// Registered N-to-1 round-robin arbiter stage with valid/ready on every input and the output.
// The winner is presented as captured data plus a one-hot position and a binary index.
module rr_arb_stage #(
  parameter int unsigned DATA      = 32,
  parameter int unsigned IN        = 4,
  parameter int unsigned IDX_WIDTH = ($clog2(IN) > 0 ? $clog2(IN) : 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IN-1:0]        in_valid,
  input  logic [DATA*IN-1:0]   in_data,
  output logic [IN-1:0]        in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA-1:0]      out_data,
  output logic [IN-1:0]        out_pos,
  output logic [IDX_WIDTH-1:0] out_idx
);

  logic                 out_valid_q;
  logic [DATA-1:0]      out_data_q, out_data_d;
  logic [IN-1:0]        out_pos_q, out_pos_d;
  logic [IDX_WIDTH-1:0] out_idx_q;
  logic [IDX_WIDTH-1:0] ptr_q, ptr_d;

  logic                 load;
  logic                 found;
  logic [IDX_WIDTH-1:0] win_idx;
  int unsigned          scan_j;

  // The register can refill while it is being drained, giving one transfer per cycle.
  assign load = !out_valid_q || out_ready;

  // Scan upward from ptr, wrapping at IN-1; first requester found wins.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    scan_j  = 0;
    for (int unsigned k = 0; k < IN; k++) begin
      scan_j = 32'(ptr_q) + k;
      if (scan_j >= IN) begin
        scan_j = scan_j - IN;
      end
      if (!found && in_valid[scan_j]) begin
        found   = 1'b1;
        win_idx = IDX_WIDTH'(scan_j);
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (load && found) begin
      in_ready[win_idx] = 1'b1;
    end
  end

  always_comb begin
    out_data_d = in_data[DATA*win_idx +: DATA];
    out_pos_d  = '0;
    out_pos_d[win_idx] = 1'b1;
    if (win_idx == IDX_WIDTH'(IN - 1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_pos_q   <= '0;
      out_idx_q   <= '0;
      ptr_q       <= '0;
    end else if (load) begin
      if (found) begin
        out_valid_q <= 1'b1;
        out_data_q  <= out_data_d;
        out_pos_q   <= out_pos_d;
        out_idx_q   <= win_idx;
        ptr_q       <= ptr_d;
      end else begin
        // Payload holds; only out_valid qualifies it.
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_pos   = out_pos_q;
  assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_rr_arb_stage.sv
// Directed-vector bench for rr_arb_stage: a 4-input/32-bit instance and a 3-input/8-bit instance.
module tb_rr_arb_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // IN=4, DATA=32 instance
  logic        reset;
  logic [3:0]  in_valid;
  logic [127:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_pos;
  logic [1:0]  out_idx;

  // IN=3, DATA=8 instance
  logic        r3_reset;
  logic [2:0]  r3_in_valid;
  logic [23:0] r3_in_data;
  logic [2:0]  r3_in_ready;
  logic        r3_out_valid;
  logic        r3_out_ready;
  logic [7:0]  r3_out_data;
  logic [2:0]  r3_out_pos;
  logic [1:0]  r3_out_idx;

  int nvec = 0;
  int nerr = 0;

  rr_arb_stage #(.DATA(32), .IN(4)) u_dut4 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_pos   (out_pos),
    .out_idx   (out_idx)
  );

  rr_arb_stage #(.DATA(8), .IN(3)) u_dut3 (
    .clk       (clk),
    .reset     (r3_reset),
    .in_valid  (r3_in_valid),
    .in_data   (r3_in_data),
    .in_ready  (r3_in_ready),
    .out_valid (r3_out_valid),
    .out_ready (r3_out_ready),
    .out_data  (r3_out_data),
    .out_pos   (r3_out_pos),
    .out_idx   (r3_out_idx)
  );

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    in_data   = {32'd4, 32'd3, 32'd2, 32'd1};
    step();
    step();
    reset = 1'b0;
    nvec++;
    if (out_valid !== 1'b0) begin
      nerr++; $display("FAIL reset_valid got=%b exp=0", out_valid);
    end
    nvec++;
    if (out_data !== 32'd0 || out_pos !== 4'b0000 || out_idx !== 2'd0) begin
      nerr++;
      $display("FAIL reset_outputs got data=%0d pos=%b idx=%0d exp 0/0000/0",
               out_data, out_pos, out_idx);
    end
    nvec++;
    if (in_ready !== 4'b0000) begin
      nerr++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready);
    end
  endtask

  task automatic test_rotation();
    logic [1:0]  exp_idx [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [31:0] exp_dat [5] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd1};
    logic [3:0]  exp_pos [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      nvec++;
      if (in_ready !== exp_pos[i]) begin
        nerr++; $display("FAIL rot_in_ready[%0d] got=%b exp=%b", i, in_ready, exp_pos[i]);
      end
      step();
      nvec++;
      if (out_valid !== 1'b1 || out_idx !== exp_idx[i] || out_data !== exp_dat[i] ||
          out_pos !== exp_pos[i]) begin
        nerr++;
        $display("FAIL rot_out[%0d] got v=%b idx=%0d data=%0d pos=%b exp 1/%0d/%0d/%b",
                 i, out_valid, out_idx, out_data, out_pos, exp_idx[i], exp_dat[i], exp_pos[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    // ptr is 1 after the rotation test: next grant is idx 1.
    step();
    nvec++;
    if (out_idx !== 2'd1 || out_data !== 32'd2) begin
      nerr++; $display("FAIL bp_setup got idx=%0d data=%0d exp 1/2", out_idx, out_data);
    end
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if (in_ready !== 4'b0000) begin
        nerr++; $display("FAIL bp_in_ready[%0d] got=%b exp=0000", i, in_ready);
      end
      step();
      nvec++;
      if (out_valid !== 1'b1 || out_idx !== 2'd1 || out_data !== 32'd2) begin
        nerr++;
        $display("FAIL bp_hold[%0d] got v=%b idx=%0d data=%0d exp 1/1/2",
                 i, out_valid, out_idx, out_data);
      end
    end
    out_ready = 1'b1;
    #1;
    nvec++;
    if (in_ready !== 4'b0100) begin
      nerr++; $display("FAIL bp_release_ready got=%b exp=0100", in_ready);
    end
    step();
    nvec++;
    if (out_idx !== 2'd2 || out_data !== 32'd3 || out_pos !== 4'b0100) begin
      nerr++;
      $display("FAIL bp_release_grant got idx=%0d data=%0d pos=%b exp 2/3/0100",
               out_idx, out_data, out_pos);
    end
  endtask

  task automatic test_sparse();
    logic [1:0] exp_idx [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
    logic [3:0] exp_pos [4] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
    reset = 1'b1;
    step();
    reset    = 1'b0;
    in_valid = 4'b1010;
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (in_ready !== exp_pos[i]) begin
        nerr++; $display("FAIL sparse_ready[%0d] got=%b exp=%b", i, in_ready, exp_pos[i]);
      end
      step();
      nvec++;
      if (out_valid !== 1'b1 || out_idx !== exp_idx[i] || out_pos !== exp_pos[i]) begin
        nerr++;
        $display("FAIL sparse_out[%0d] got v=%b idx=%0d pos=%b exp 1/%0d/%b",
                 i, out_valid, out_idx, out_pos, exp_idx[i], exp_pos[i]);
      end
    end
  endtask

  task automatic test_wrap();
    // ptr is 0 here; grant idx 2 so ptr becomes 3.
    in_valid = 4'b0100;
    step();
    nvec++;
    if (out_idx !== 2'd2 || out_data !== 32'd3) begin
      nerr++; $display("FAIL wrap_setup got idx=%0d data=%0d exp 2/3", out_idx, out_data);
    end
    in_valid = 4'b0101;
    #1;
    nvec++;
    if (in_ready !== 4'b0001) begin
      nerr++; $display("FAIL wrap_ready got=%b exp=0001", in_ready);
    end
    step();
    nvec++;
    if (out_idx !== 2'd0 || out_data !== 32'd1 || out_pos !== 4'b0001) begin
      nerr++;
      $display("FAIL wrap_grant0 got idx=%0d data=%0d pos=%b exp 0/1/0001",
               out_idx, out_data, out_pos);
    end
    step();
    nvec++;
    if (out_idx !== 2'd2 || out_data !== 32'd3) begin
      nerr++; $display("FAIL wrap_grant2 got idx=%0d data=%0d exp 2/3", out_idx, out_data);
    end
  endtask

  task automatic test_reset_midstream();
    // ptr is 3; grant idx 1 leaves ptr=2 with out_valid=1.
    in_valid = 4'b0010;
    step();
    nvec++;
    if (out_valid !== 1'b1 || out_idx !== 2'd1) begin
      nerr++; $display("FAIL mid_setup got v=%b idx=%0d exp 1/1", out_valid, out_idx);
    end
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    reset     = 1'b1;
    #1;
    nvec++;
    if (in_ready !== 4'b0000) begin
      nerr++; $display("FAIL mid_ready_stalled got=%b exp=0000", in_ready);
    end
    step();
    reset = 1'b0;
    #1;
    nvec++;
    if (out_valid !== 1'b0 || out_data !== 32'd0 || out_pos !== 4'b0000 ||
        out_idx !== 2'd0) begin
      nerr++;
      $display("FAIL mid_cleared got v=%b data=%0d pos=%b idx=%0d exp 0/0/0000/0",
               out_valid, out_data, out_pos, out_idx);
    end
    nvec++;
    if (in_ready !== 4'b0001) begin
      nerr++; $display("FAIL mid_first_ready got=%b exp=0001", in_ready);
    end
    step();
    nvec++;
    if (out_valid !== 1'b1 || out_idx !== 2'd0 || out_data !== 32'd1) begin
      nerr++;
      $display("FAIL mid_first_grant got v=%b idx=%0d data=%0d exp 1/0/1",
               out_valid, out_idx, out_data);
    end
    // Empty inputs with a drain clear out_valid but hold the payload.
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    step();
    nvec++;
    if (out_valid !== 1'b0 || out_idx !== 2'd0 || out_data !== 32'd1) begin
      nerr++;
      $display("FAIL drain_empty got v=%b idx=%0d data=%0d exp 0/0/1",
               out_valid, out_idx, out_data);
    end
  endtask

  task automatic test_in3();
    logic [1:0] exp_idx [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    logic [2:0] exp_pos [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [7:0] exp_dat [4] = '{8'd1, 8'd2, 8'd3, 8'd1};
    r3_reset = 1'b0;
    r3_in_valid  = 3'b111;
    r3_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      nvec++;
      if (r3_out_valid !== 1'b1 || r3_out_idx !== exp_idx[i] || r3_out_pos !== exp_pos[i] ||
          r3_out_data !== exp_dat[i]) begin
        nerr++;
        $display("FAIL in3_out[%0d] got v=%b idx=%0d pos=%b data=%0d exp 1/%0d/%b/%0d",
                 i, r3_out_valid, r3_out_idx, r3_out_pos, r3_out_data,
                 exp_idx[i], exp_pos[i], exp_dat[i]);
      end
    end
    r3_in_valid = 3'b000;
    step();
    nvec++;
    if (r3_out_valid !== 1'b0 || r3_out_idx !== 2'd0) begin
      nerr++;
      $display("FAIL in3_drop got v=%b idx=%0d exp 0/0", r3_out_valid, r3_out_idx);
    end
  endtask

  initial begin
    r3_reset     = 1'b1;
    r3_in_valid  = 3'b000;
    r3_out_ready = 1'b0;
    r3_in_data   = {8'd3, 8'd2, 8'd1};
    test_reset();
    test_rotation();
    test_backpressure();
    test_sparse();
    test_wrap();
    test_reset_midstream();
    test_in3();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
